// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequencer driving an external Alu32 for shift-add multiply and restoring divide
// Divide path is present only when ALU_SEQ_DIV_EN is defined.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             accept, short_op, b_top, carry, last;

`ifdef ALU_SEQ_DIV_EN
  logic             op_q, op_d;
  logic [WIDTH-1:0] rsh;
  logic             ge;
  assign rsh      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign short_op = op && (opb == '0);
`else
  assign short_op = op;
`endif

  assign accept = (state_q == IDLE) && start;
  assign last   = (count_q == CW'(WIDTH - 1));

  // The ALU has no carry-out, so rebuild it from the sign bits of what was actually applied.
  assign b_top = alu_ctl[2] ? ~alu_b[WIDTH-1] : alu_b[WIDTH-1];
  assign carry = (alu_a[WIDTH-1] & b_top) | ((alu_a[WIDTH-1] | b_top) & ~alu_s[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
  assign ge    = hi_q[WIDTH-1] | carry;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = short_op ? DONE : RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_ctl = 4'b0000;
    alu_a   = '0;
    alu_b   = '0;
    if (state_q == RUN) begin
`ifdef ALU_SEQ_DIV_EN
      if (op_q) begin
        alu_ctl = 4'b0110;
        alu_a   = rsh;
        alu_b   = m_q;
      end else begin
        alu_ctl = 4'b0010;
        alu_a   = hi_q;
        alu_b   = lo_q[0] ? m_q : '0;
      end
`else
      alu_ctl = 4'b0010;
      alu_a   = hi_q;
      alu_b   = lo_q[0] ? m_q : '0;
`endif
    end
  end

  always_comb begin
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
`ifdef ALU_SEQ_DIV_EN
    op_d     = op_q;
`endif
    if (accept) begin
      count_d = '0;
      hi_d    = '0;
`ifdef ALU_SEQ_DIV_EN
      op_d    = op;
      lo_d    = op ? opa : opb;
      m_d     = op ? opb : opa;
      if (short_op) begin
        res_hi_d = opa;
        res_lo_d = '1;
      end
`else
      lo_d    = opb;
      m_d     = opa;
      if (short_op) begin
        res_hi_d = '0;
        res_lo_d = '0;
      end
`endif
    end else if (state_q == RUN) begin
      count_d = count_q + 1'b1;
`ifdef ALU_SEQ_DIV_EN
      if (op_q) begin
        hi_d = ge ? alu_s : rsh;
        lo_d = {lo_q[WIDTH-2:0], ge};
      end else begin
        hi_d = {carry, alu_s[WIDTH-1:1]};
        lo_d = {alu_s[0], lo_q[WIDTH-1:1]};
      end
`else
      hi_d = {carry, alu_s[WIDTH-1:1]};
      lo_d = {alu_s[0], lo_q[WIDTH-1:1]};
`endif
      if (last) begin
        res_hi_d = hi_d;
        res_lo_d = lo_d;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed vector bench for alu_muldiv_seq with a behavioural Alu32
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic        busy, done;
  logic [31:0] result_hi, result_lo;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s)
  );

  logic [31:0] ma, mb, msum;
  always_comb begin
    ma   = alu_ctl[3] ? ~alu_a : alu_a;
    mb   = alu_ctl[2] ? ~alu_b : alu_b;
    msum = ma + mb + {31'b0, alu_ctl[2]};
    case (alu_ctl[1:0])
      2'b00:   alu_s = ma & mb;
      2'b01:   alu_s = ma | mb;
      2'b10:   alu_s = msum;
      default: alu_s = {31'b0, msum[31]};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    int          inject;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
    logic [3:0]  exp_ctl;
  } vec_t;

  // Starts one op; k counts cycles after the accept cycle, start is re-pulsed at k==inject.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input int inject,
                        output int lat, output int busy_cnt, output int done_cnt, output logic [3:0] ctl2);
    lat = -1; busy_cnt = 0; done_cnt = 0; ctl2 = 4'hx;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == inject);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (k == 2) ctl2 = alu_ctl;
    end
    start = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    int lat, bc, dc;
    logic [3:0] c2;
    logic [31:0] div_hi, div_lo;
    int div_lat;
    logic [3:0] div_ctl;

    vecs[0]  = '{1'b0, 32'd7,        32'd6,        0,  32'h0,        32'd42,       33, 4'b0010};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'hFFFFFFFE, 32'h00000001, 33, 4'b0010};
    vecs[2]  = '{1'b0, 32'h00010000, 32'h00010000, 0,  32'h1,        32'h0,        33, 4'b0010};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'd2,        0,  32'h1,        32'hFFFFFFFE, 33, 4'b0010};
    vecs[4]  = '{1'b0, 32'h0,        32'h12345678, 0,  32'h0,        32'h0,        33, 4'b0010};
    vecs[5]  = '{1'b0, 32'd3,        32'd4,        10, 32'h0,        32'd12,       33, 4'b0010};
    vecs[6]  = '{1'b0, 32'd3,        32'd4,        33, 32'h0,        32'd12,       33, 4'b0010};
`ifdef ALU_SEQ_DIV_EN
    vecs[7]  = '{1'b1, 32'd100,      32'd7,        0,  32'd2,        32'd14,       33, 4'b0110};
    vecs[8]  = '{1'b1, 32'h80000000, 32'd3,        0,  32'd2,        32'h2AAAAAAA, 33, 4'b0110};
    vecs[9]  = '{1'b1, 32'd5,        32'd0,        0,  32'd5,        32'hFFFFFFFF, 1,  4'b0000};
    vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'd1,        0,  32'd0,        32'hFFFFFFFF, 33, 4'b0110};
    vecs[11] = '{1'b1, 32'd3,        32'd10,       0,  32'd3,        32'd0,        33, 4'b0110};
`else
    vecs[7]  = '{1'b1, 32'd100,      32'd7,        0,  32'd0,        32'd0,        1,  4'b0000};
    vecs[8]  = '{1'b1, 32'h80000000, 32'd3,        0,  32'd0,        32'd0,        1,  4'b0000};
    vecs[9]  = '{1'b1, 32'd5,        32'd0,        0,  32'd0,        32'd0,        1,  4'b0000};
    vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'd1,        0,  32'd0,        32'd0,        1,  4'b0000};
    vecs[11] = '{1'b1, 32'd3,        32'd10,       0,  32'd0,        32'd0,        1,  4'b0000};
`endif

    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_hi", result_hi, 32'h0);
    check("rst_lo", result_lo, 32'h0);
    check("rst_alu", {28'b0, alu_ctl} | alu_a | alu_b, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inject, lat, bc, dc, c2);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_lat);
      check($sformatf("v%0d_done_pulses", i), dc, 1);
      check($sformatf("v%0d_ctl", i), {28'b0, c2}, {28'b0, vecs[i].exp_ctl});
      check($sformatf("v%0d_hi", i), result_hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), result_lo, vecs[i].exp_lo);
      check($sformatf("v%0d_idle_alu", i), {28'b0, alu_ctl} | alu_a | alu_b, 32'h0);
    end

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_done", {31'b0, done}, 32'h0);
    check("mid_rst_hi", result_hi, 32'h0);
    check("mid_rst_lo", result_lo, 32'h0);
    check("mid_rst_ctl", {28'b0, alu_ctl}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd9, 32'd11, 0, lat, bc, dc, c2);
    check("post_rst_lat", lat, 33);
    check("post_rst_done_pulses", dc, 1);
    check("post_rst_lo", result_lo, 32'd99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
